// File: rtl/present_pkg.sv
// Shared PRESENT definitions: S-box tables, bit permutations, round count and FSM states.
// Decryption support elsewhere is enabled by defining PRESENT_DEC_EN.
package present_pkg;

  localparam int ROUNDS = 31;
  localparam logic [4:0] RC_LAST = 5'(ROUNDS);

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, FINAL} fsm_t;

  // Nibble n of each table holds the substitution for input value n.
  localparam logic [63:0] SBOX_TBL     = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] INV_SBOX_TBL = 64'hA970_364B_D21C_8FE5;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return INV_SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox(x[4*i +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] inv_sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = inv_sbox(x[4*i +: 4]);
    return y;
  endfunction

  // Bit i moves to position 16*i mod 63; bit 63 stays put.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y[63] = x[63];
    for (int i = 0; i < 63; i++) y[(16*i) % 63] = x[i];
    return y;
  endfunction

  function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
    logic [63:0] y;
    y[63] = x[63];
    for (int i = 0; i < 63; i++) y[i] = x[(16*i) % 63];
    return y;
  endfunction

endpackage

// File: rtl/present_key_sched.sv
// PRESENT key schedule step for 80- or 128-bit keys; the inverse step exists
// only when PRESENT_DEC_EN is defined.
module present_key_sched
  import present_pkg::*;
#(
  parameter int KEY_W = 80
) (
  input  logic [KEY_W-1:0] key_cur,
  input  logic [4:0]       rc,
`ifdef PRESENT_DEC_EN
  output logic [KEY_W-1:0] key_inv,
`endif
  output logic [KEY_W-1:0] key_fwd
);

  if (KEY_W == 80) begin : g_k80
    always_comb begin
      // NOTE: the whole output is assigned first, so no path leaves it unassigned and no latch appears.
      key_fwd          = {key_cur[18:0], key_cur[79:19]};
      key_fwd[79:76]   = sbox(key_fwd[79:76]);
      key_fwd[19:15]   = key_fwd[19:15] ^ rc;
    end
`ifdef PRESENT_DEC_EN
    logic [79:0] undo;
    always_comb begin
      undo          = key_cur;
      undo[19:15]   = undo[19:15] ^ rc;
      undo[79:76]   = inv_sbox(undo[79:76]);
      key_inv       = {undo[60:0], undo[79:61]};
    end
`endif
  end else if (KEY_W == 128) begin : g_k128
    always_comb begin
      key_fwd          = {key_cur[66:0], key_cur[127:67]};
      key_fwd[127:124] = sbox(key_fwd[127:124]);
      key_fwd[123:120] = sbox(key_fwd[123:120]);
      key_fwd[66:62]   = key_fwd[66:62] ^ rc;
    end
`ifdef PRESENT_DEC_EN
    logic [127:0] undo;
    always_comb begin
      undo           = key_cur;
      undo[66:62]    = undo[66:62] ^ rc;
      undo[127:124]  = inv_sbox(undo[127:124]);
      undo[123:120]  = inv_sbox(undo[123:120]);
      key_inv        = {undo[60:0], undo[127:61]};
    end
`endif
  end else begin : g_bad_key_w
    $error("present_key_sched: KEY_W must be 80 or 128");
  end

endmodule

// File: rtl/present_core.sv
// Iterative PRESENT block cipher, one round per cycle. Decryption (mode=1) is
// compiled in only when PRESENT_DEC_EN is defined; otherwise mode is ignored.
module present_core
  import present_pkg::*;
#(
  parameter int KEY_W = 80
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [KEY_W-1:0] key,
  input  logic [63:0]      din,
  output logic             busy,
  output logic             done,
  output logic [63:0]      dout
);

  fsm_t             fsm;
  logic [63:0]      state;
  logic [KEY_W-1:0] key_reg;
  logic [KEY_W-1:0] key_fwd;
  logic [4:0]       rc;
  logic [63:0]      round_key;
  logic [63:0]      enc_next;

  assign round_key = key_reg[KEY_W-1 -: 64];
  assign enc_next  = p_layer(sbox_layer(state ^ round_key));

`ifdef PRESENT_DEC_EN
  logic             mode_reg;
  logic [KEY_W-1:0] key_inv;
  logic [63:0]      dec_next;

  // Decrypt rounds walk the schedule backwards, so the previous round key is used here.
  assign dec_next = inv_sbox_layer(inv_p_layer(state)) ^ key_inv[KEY_W-1 -: 64];
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  present_key_sched #(.KEY_W(KEY_W)) u_key_sched (
    .key_cur (key_reg),
    .rc      (rc),
`ifdef PRESENT_DEC_EN
    .key_inv (key_inv),
`endif
    .key_fwd (key_fwd)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= IDLE;
      state    <= '0;
      key_reg  <= '0;
      rc       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout     <= '0;
`ifdef PRESENT_DEC_EN
      mode_reg <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: if (start) begin
          state   <= din;
          key_reg <= key;
          rc      <= 5'd1;
          busy    <= 1'b1;
`ifdef PRESENT_DEC_EN
          mode_reg <= mode;
          fsm      <= mode ? KEYEXP : ROUND;
`else
          fsm      <= ROUND;
`endif
        end
`ifdef PRESENT_DEC_EN
        KEYEXP: begin
          key_reg <= key_fwd;
          if (rc == RC_LAST) begin
            state <= state ^ key_fwd[KEY_W-1 -: 64];
            fsm   <= ROUND;
          end else begin
            rc <= rc + 5'd1;
          end
        end
`endif
        ROUND: begin
`ifdef PRESENT_DEC_EN
          if (mode_reg) begin
            state   <= dec_next;
            key_reg <= key_inv;
            if (rc == 5'd1) fsm <= FINAL;
            else            rc  <= rc - 5'd1;
          end else
`endif
          begin
            state   <= enc_next;
            key_reg <= key_fwd;
            if (rc == RC_LAST) fsm <= FINAL;
            else               rc  <= rc + 5'd1;
          end
        end
        FINAL: begin
`ifdef PRESENT_DEC_EN
          dout <= mode_reg ? state : state ^ round_key;
`else
          dout <= state ^ round_key;
`endif
          done <= 1'b1;
          busy <= 1'b0;
          fsm  <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_core.sv
// Self-checking bench for present_core (KEY_W=80 and KEY_W=128 side by side),
// with decrypt vectors exercised when PRESENT_DEC_EN is defined.
module tb_present_core;

`ifdef PRESENT_DEC_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  localparam int SB [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [79:0]  key80 = '0;
  logic [127:0] key128 = '0;
  logic [63:0]  din = '0;
  logic         busy80, done80, busy128, done128;
  logic [63:0]  dout80, dout128;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  present_core #(.KEY_W(80)) dut80 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key(key80),
    .din(din), .busy(busy80), .done(done80), .dout(dout80)
  );

  present_core #(.KEY_W(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key(key128),
    .din(din), .busy(busy128), .done(done128), .dout(dout128)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: the cipher written straight from its definition
  function automatic logic [3:0] m_isb(input logic [3:0] y);
    for (int v = 0; v < 16; v++) if (SB[v] == int'(y)) return 4'(v);
    return 4'd0;
  endfunction

  function automatic logic [63:0] m_sub(input logic [63:0] s, input bit inv);
    logic [63:0] o;
    for (int n = 0; n < 16; n++) o[4*n +: 4] = inv ? m_isb(s[4*n +: 4]) : 4'(SB[s[4*n +: 4]]);
    return o;
  endfunction

  function automatic logic [63:0] m_perm(input logic [63:0] s, input bit inv);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) begin
      if (inv) o[i] = s[16*(i%4) + i/4];
      else     o[16*(i%4) + i/4] = s[i];
    end
    return o;
  endfunction

  function automatic logic [127:0] m_kstep(input logic [127:0] k, input int kw, input int r);
    logic [127:0] mask;
    int pos;
    mask = (kw == 128) ? '1 : ((128'd1 << kw) - 128'd1);
    k = ((k << 61) | (k >> (kw - 61))) & mask;
    k[kw-4 +: 4] = 4'(SB[k[kw-4 +: 4]]);
    if (kw == 128) k[kw-8 +: 4] = 4'(SB[k[kw-8 +: 4]]);
    pos = (kw == 80) ? 15 : 62;
    k[pos +: 5] = k[pos +: 5] ^ 5'(r);
    return k;
  endfunction

  function automatic logic [63:0] m_cipher(input logic [127:0] k, input int kw,
                                           input logic [63:0] blk, input bit dec);
    logic [63:0]  rk [1:32];
    logic [127:0] kk;
    logic [63:0]  s;
    kk = k;
    rk[1] = 64'(kk >> (kw - 64));
    for (int r = 1; r <= 31; r++) begin
      kk = m_kstep(kk, kw, r);
      rk[r+1] = 64'(kk >> (kw - 64));
    end
    if (!dec) begin
      s = blk;
      for (int r = 1; r <= 31; r++) s = m_perm(m_sub(s ^ rk[r], 1'b0), 1'b0);
      return s ^ rk[32];
    end
    s = blk ^ rk[32];
    for (int r = 31; r >= 1; r--) s = m_sub(m_perm(s, 1'b1), 1'b1) ^ rk[r];
    return s;
  endfunction

  // ---------------- cycle model: remaining cycles until done for each width
  int          rem [2];
  logic [63:0] pend [2];
  logic [63:0] m_dout [2];
  logic        m_done [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        rem[d] <= 0; pend[d] <= '0; m_dout[d] <= '0; m_done[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_done[d] <= 1'b0;
        if (rem[d] > 0) begin
          rem[d] <= rem[d] - 1;
          if (rem[d] == 1) begin
            m_done[d] <= 1'b1;
            m_dout[d] <= pend[d];
          end
        end else if (start) begin
          rem[d]  <= (DEC && mode) ? 63 : 32;
          pend[d] <= m_cipher(d == 0 ? {48'h0, key80} : key128, d == 0 ? 80 : 128,
                              din, DEC && mode);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (done80) done_cnt++;
    check("busy80", {63'b0, busy80}, {63'b0, rem[0] != 0});
    check("done80", {63'b0, done80}, {63'b0, m_done[0]});
    check("dout80", dout80, m_dout[0]);
    check("busy128", {63'b0, busy128}, {63'b0, rem[1] != 0});
    check("done128", {63'b0, done128}, {63'b0, m_done[1]});
    check("dout128", dout128, m_dout[1]);
  end

  // ---------------- directed operations
  task automatic run_op(input logic m, input logic [79:0] k80, input logic [127:0] k128,
                        input logic [63:0] d, input int pulse_at, input int rst_at,
                        output int lat, output logic [63:0] r80, output logic [63:0] r128);
    int n;
    bit got;
    n = 0; got = 1'b0; lat = -1; r80 = '0; r128 = '0;
    @(negedge clk);
    mode = m; key80 = k80; key128 = k128; din = d; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk); #1; n++;
      start = (n == pulse_at);
      if (n == pulse_at) din = ~d;
      if (n == rst_at) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy80", {63'b0, busy80}, 64'd0);
        check("abort_busy128", {63'b0, busy128}, 64'd0);
        check("abort_done80", {63'b0, done80}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        got = 1'b1;
      end else if (done80) begin
        got = 1'b1; lat = n; r80 = dout80; r128 = dout128;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL op_timeout: no done after %0d cycles", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, dc, last, cnt, n;
    logic [63:0] r80, r128;

    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, busy80}, 64'd0);
    check("rst_done", {63'b0, done80}, 64'd0);
    check("rst_dout", dout80, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    check("model_kat80_zero", m_cipher('0, 80, '0, 1'b0), 64'h5579C1387B228445);
    check("model_kat80_ones", m_cipher({48'h0, {80{1'b1}}}, 80, '1, 1'b0), 64'h3333DCD3213210D2);
    check("model_kat80_k1", m_cipher({48'h0, {80{1'b1}}}, 80, '0, 1'b0), 64'hE72C46C0F5945049);
    check("model_kat128_zero", m_cipher('0, 128, '0, 1'b0), 64'h96DB702A2E6900AF);
    check("model_dec80", m_cipher('0, 80, 64'h5579C1387B228445, 1'b1), 64'h0);

    run_op(1'b0, '0, '0, '0, -1, -1, lat, r80, r128);
    check("enc_latency", 64'(lat), 64'd32);
    check("kat80_zero", r80, 64'h5579C1387B228445);
    check("kat128_zero", r128, 64'h96DB702A2E6900AF);

    run_op(1'b0, '1, '1, '1, -1, -1, lat, r80, r128);
    check("kat80_ones", r80, 64'h3333DCD3213210D2);

    run_op(1'b0, '1, 128'h0123456789ABCDEF_FEDCBA9876543210, '0, -1, -1, lat, r80, r128);
    check("kat80_k1", r80, 64'hE72C46C0F5945049);

    run_op(1'b0, '0, '0, '0, 10, -1, lat, r80, r128);
    check("busy_start_latency", 64'(lat), 64'd32);
    check("busy_start_result", r80, 64'h5579C1387B228445);

    run_op(1'b0, '1, '1, 64'h0123_4567_89AB_CDEF, -1, 15, lat, r80, r128);
    dc = done_cnt;
    repeat (40) @(posedge clk);
    check("abort_no_done", 64'(done_cnt - dc), 64'd0);
    run_op(1'b0, '1, '0, '0, -1, -1, lat, r80, r128);
    check("after_abort_latency", 64'(lat), 64'd32);
    check("after_abort_result", r80, 64'hE72C46C0F5945049);

    @(negedge clk);
    mode = 1'b0; key80 = 80'hDEAD_BEEF_0123_4567_89AB; key128 = ~key128;
    din = 64'hA5A5_5A5A_0F0F_F0F0; start = 1'b1;
    last = -1; cnt = 0; n = 0;
    while (cnt < 4 && n < 300) begin
      @(posedge clk); #1; n++;
      if (done80) begin
        if (last >= 0) check("b2b_gap", 64'(n - last), 64'd33);
        last = n; cnt++;
        din = din + 64'h1111_1111_1111_1111;
      end
    end
    start = 1'b0;
    check("b2b_count", 64'(cnt), 64'd4);
    repeat (40) @(posedge clk);

`ifdef PRESENT_DEC_EN
    run_op(1'b1, '0, '0, 64'h5579C1387B228445, -1, -1, lat, r80, r128);
    check("dec_latency", 64'(lat), 64'd63);
    check("dec80_zero", r80, 64'h0);
    run_op(1'b1, '0, '0, 64'h96DB702A2E6900AF, -1, -1, lat, r80, r128);
    check("dec128_zero", r128, 64'h0);
    run_op(1'b1, '1, '1, 64'h3333DCD3213210D2, -1, -1, lat, r80, r128);
    check("dec80_ones", r80, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    run_op(1'b1, '0, '0, '0, -1, -1, lat, r80, r128);
    check("mode_ignored_latency", 64'(lat), 64'd32);
    check("mode_ignored_result", r80, 64'h5579C1387B228445);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
